// File: rtl/jam_pkg.sv
// jam_pkg: shared constants and types for the JAM cost table and engine
package jam_pkg;
    localparam int N_WORKER = 8;
    localparam int N_JOB    = 8;
    localparam int COST_W   = 7;
    localparam int SUM_W    = 10;
    typedef logic [COST_W-1:0] cost_t;
    typedef logic [2:0]        idx_t;
    typedef logic [SUM_W-1:0]  sum_t;
    typedef enum logic {LOAD, READY} tbl_state_e;
endpackage

// File: rtl/jam_row_min.sv
// jam_row_min: streaming per-row minimum and lower-bound accumulator
module jam_row_min
    import jam_pkg::*;
(
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     clr,
    input  logic                     fire,
    input  idx_t                     row,
    input  idx_t                     col,
    input  cost_t                    data,
    output cost_t [N_WORKER-1:0]     rowmin,
    output sum_t                     lb
);
    cost_t                 run_q, run_d, cur;
    cost_t [N_WORKER-1:0]  rm_q, rm_d;
    sum_t                  lb_q, lb_d;

    // running minimum restarts on column 0; the last column commits it to the row slot and the bound
    always_comb begin
        cur  = (col == '0 || data < run_q) ? data : run_q;
        run_d = run_q;
        rm_d  = rm_q;
        lb_d  = lb_q;
        if (clr) begin
            run_d = '0;
            rm_d  = '0;
            lb_d  = '0;
        end else if (fire) begin
            run_d = cur;
            if (col == idx_t'(N_JOB - 1)) begin
                rm_d[row] = cur;
                lb_d      = lb_q + sum_t'(cur);
            end
        end
    end

    // state registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            run_q <= '0;
            rm_q  <= '0;
            lb_q  <= '0;
        end else begin
            run_q <= run_d;
            rm_q  <= rm_d;
            lb_q  <= lb_d;
        end
    end

    assign rowmin = rm_q;
    assign lb     = lb_q;
endmodule

// File: rtl/jam_cost_table.sv
// jam_cost_table: loads the 8x8 cost matrix and serves registered lookups, row minima and lower bound
module jam_cost_table
    import jam_pkg::*;
(
    input  logic  CLK,
    input  logic  RST,
    input  logic  ld_start,
    input  logic  ld_valid,
    input  cost_t ld_data,
    output logic  ld_ready,
    output logic  tbl_ready,
    output logic  ld_err,
    input  idx_t  W,
    input  idx_t  J,
    output cost_t Cost,
    input  idx_t  rm_w,
    output cost_t RowMin,
    output sum_t  LowerBound
);
    tbl_state_e                    state_q, state_d;
    logic [5:0]                    cnt_q, cnt_d;
    cost_t [N_WORKER*N_JOB-1:0]    mem_q, mem_d;
    logic                          err_q, err_d;
    cost_t                         cost_q, cost_d, rmo_q, rmo_d;
    cost_t [N_WORKER-1:0]          rowmin;
    logic                          fire;

    assign ld_ready  = state_q == LOAD;
    assign tbl_ready = state_q == READY;
    assign fire      = ld_ready && ld_valid && !ld_start;

    // load FSM, table write and lookups; reads see the pre-write contents
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mem_d   = mem_q;
        err_d   = err_q | (ld_valid & ~ld_ready);
        cost_d  = mem_q[{W, J}];
        rmo_d   = rowmin[rm_w];
        if (ld_start) begin
            state_d = LOAD;
            cnt_d   = '0;
        end else if (fire) begin
            mem_d[cnt_q] = ld_data;
            cnt_d        = cnt_q + 6'd1;
            if (cnt_q == '1) state_d = READY;
        end
    end

    // state registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= LOAD;
            cnt_q   <= '0;
            mem_q   <= '0;
            err_q   <= 1'b0;
            cost_q  <= '0;
            rmo_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mem_q   <= mem_d;
            err_q   <= err_d;
            cost_q  <= cost_d;
            rmo_q   <= rmo_d;
        end
    end

    jam_row_min u_row_min (
        .CLK    (CLK),
        .RST    (RST),
        .clr    (ld_start),
        .fire   (fire),
        .row    (cnt_q[5:3]),
        .col    (cnt_q[2:0]),
        .data   (ld_data),
        .rowmin (rowmin),
        .lb     (LowerBound)
    );

    assign ld_err = err_q;
    assign Cost   = cost_q;
    assign RowMin = rmo_q;
endmodule

// File: tb/tb_jam_cost_table.sv
// tb_jam_cost_table: model-based and directed checks of the cost table server
module tb_jam_cost_table;
    logic       CLK = 0, RST = 1, ld_start = 0, ld_valid = 0;
    logic [6:0] ld_data = 0, Cost, RowMin;
    logic [2:0] W = 0, J = 0, rm_w = 0;
    logic       ld_ready, tbl_ready, ld_err;
    logic [9:0] LowerBound;

    int n_chk = 0, n_fail = 0;
    int m_tbl [64];
    int m_rm [8];
    int m_lb = 0, m_cnt = 0, m_cost = 0, m_rmo = 0;
    bit m_ready = 0, m_err = 0, started = 0;

    jam_cost_table dut (
        .CLK(CLK), .RST(RST), .ld_start(ld_start), .ld_valid(ld_valid), .ld_data(ld_data),
        .ld_ready(ld_ready), .tbl_ready(tbl_ready), .ld_err(ld_err),
        .W(W), .J(J), .Cost(Cost), .rm_w(rm_w), .RowMin(RowMin), .LowerBound(LowerBound)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_step();
        int r, mn;
        if (RST) begin
            foreach (m_tbl[i]) m_tbl[i] = 0;
            foreach (m_rm[i]) m_rm[i] = 0;
            m_lb = 0; m_cnt = 0; m_ready = 0; m_err = 0; m_cost = 0; m_rmo = 0;
        end else begin
            m_cost = m_tbl[int'(W) * 8 + int'(J)];
            m_rmo  = m_rm[rm_w];
            if (ld_valid && m_ready) m_err = 1;
            if (ld_start) begin
                m_cnt = 0; m_ready = 0; m_lb = 0;
                foreach (m_rm[i]) m_rm[i] = 0;
            end else if (!m_ready && ld_valid) begin
                m_tbl[m_cnt] = int'(ld_data);
                if (m_cnt % 8 == 7) begin
                    r = m_cnt / 8;
                    mn = 127;
                    for (int j = 0; j < 8; j++) if (m_tbl[r*8+j] < mn) mn = m_tbl[r*8+j];
                    m_rm[r] = mn;
                    m_lb = 0;
                    foreach (m_rm[i]) m_lb += m_rm[i];
                end
                if (m_cnt == 63) begin
                    m_ready = 1; m_cnt = 0;
                end else m_cnt++;
            end
        end
    endtask

    initial forever begin
        @(posedge CLK);
        model_step();
        started = 1;
    end

    always @(negedge CLK) if (started) begin
        chk("cost", 32'(Cost), 32'(m_cost));
        chk("rowmin", 32'(RowMin), 32'(m_rmo));
        chk("lowerbound", 32'(LowerBound), 32'(m_lb));
        chk("tbl_ready", 32'(tbl_ready), 32'(m_ready));
        chk("ld_ready", 32'(ld_ready), 32'(!m_ready));
        chk("ld_err", 32'(ld_err), 32'(m_err));
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        step(); step();
        chk("rst_cost", 32'(Cost), 0);
        chk("rst_ld_ready", 32'(ld_ready), 1);
        chk("rst_tbl_ready", 32'(tbl_ready), 0);
        chk("rst_lb", 32'(LowerBound), 0);
        chk("rst_err", 32'(ld_err), 0);
        RST = 0;
        for (int i = 0; i < 64; i++) begin
            ld_valid = 1; ld_data = 7'(i);
            if (i == 63) chk("l1_not_ready", 32'(tbl_ready), 0);
            step();
        end
        ld_valid = 0;
        chk("l1_ready", 32'(tbl_ready), 1);
        chk("l1_lb", 32'(LowerBound), 224);
        for (int k = 0; k < 8; k++) begin
            rm_w = 3'(k); step();
            chk("l1_rowmin", 32'(RowMin), 32'(8 * k));
        end
        W = 3; J = 5; step();
        chk("l1_cost35", 32'(Cost), 29);
        for (int w = 0; w < 8; w++)
            for (int j = 0; j < 8; j++) begin
                W = 3'(w); J = 3'(j); step();
                chk("sweep", 32'(Cost), 32'(8 * w + j));
            end
        ld_start = 1; step(); ld_start = 0;
        chk("l2_restart", 32'(tbl_ready), 0);
        for (int i = 0; i < 128; i++) begin
            ld_valid = (i % 2 == 0); ld_data = 127;
            if (i == 126) chk("l2_not_ready", 32'(tbl_ready), 0);
            step();
        end
        ld_valid = 0;
        chk("l2_ready", 32'(tbl_ready), 1);
        chk("l2_lb", 32'(LowerBound), 1016);
        chk("l2_err", 32'(ld_err), 0);
        for (int k = 0; k < 8; k++) begin
            rm_w = 3'(k); step();
            chk("l2_rowmin", 32'(RowMin), 127);
        end
        ld_valid = 1; ld_data = 55; step(); step();
        ld_valid = 0; step();
        chk("err_set", 32'(ld_err), 1);
        W = 0; J = 0; step();
        chk("err_tbl_kept", 32'(Cost), 127);
        chk("err_sticky", 32'(ld_err), 1);
        ld_start = 1; step(); ld_start = 0;
        for (int i = 0; i < 30; i++) begin
            ld_valid = 1; ld_data = 100; step();
        end
        ld_valid = 0; RST = 1; step(); RST = 0;
        chk("rst_mid_err", 32'(ld_err), 0);
        chk("rst_mid_ready", 32'(tbl_ready), 0);
        for (int i = 0; i < 64; i++) begin
            ld_valid = 1;
            ld_data = (i < 8) ? ((i == 3) ? 7'd5 : 7'(20 + i)) : 7'((i * 37 + 11) % 128);
            if (i == 63) chk("l3_not_ready", 32'(tbl_ready), 0);
            step();
        end
        ld_valid = 0;
        chk("l3_ready", 32'(tbl_ready), 1);
        rm_w = 0; step();
        chk("l3_rowmin0", 32'(RowMin), 5);
        ld_start = 1; ld_valid = 1; ld_data = 99; step();
        ld_start = 0; ld_data = 7; step();
        ld_valid = 0;
        chk("l4_not_ready", 32'(tbl_ready), 0);
        W = 0; J = 0; step();
        chk("l4_first", 32'(Cost), 7);
        for (int i = 1; i < 64; i++) begin
            ld_valid = 1; ld_data = 7'(i); step();
        end
        ld_valid = 0;
        chk("l4_ready", 32'(tbl_ready), 1);
        step();
        chk("l4_cost00", 32'(Cost), 7);
        step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
